// File: rtl/upcount_pkg.sv
// Shared constants and FSM state encoding for the upcounter control stage.
package upcount_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultPreW  = 24;

  // 2'b11 is deliberately unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/upcount_ctrl_if.sv
// Control/data bundle between the upcounter control stage and its surroundings.
// The slave side is the control stage itself; the master side drives its requests.
interface upcount_ctrl_if #(
  parameter int unsigned WIDTH = upcount_pkg::DefaultWidth,
  parameter int unsigned PRE_W = upcount_pkg::DefaultPreW
);

  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] inc_d;
  logic [WIDTH-1:0] inc_q;
  logic [WIDTH-1:0] cnt_out;
  logic             wrap;
  logic             busy;
  logic [1:0]       state_o;

  modport master (
    output start, stop, clear, load, load_val, modulus, prescale, inc_d,
    input  inc_q, cnt_out, wrap, busy, state_o
  );

  modport slave (
    input  start, stop, clear, load, load_val, modulus, prescale, inc_d,
    output inc_q, cnt_out, wrap, busy, state_o
  );

endinterface

// File: rtl/tick_prescaler.sv
// Prescaler: emits a tick every prescale+1 cycles while run is high.
module tick_prescaler #(
  parameter int unsigned PRE_W = upcount_pkg::DefaultPreW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sync_clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  // Exact-equality compare: if prescale drops below pre_cnt, the counter
  // runs on and wraps through zero before the next tick.
  assign tick = run && (pre_cnt_q == prescale);

  // Next prescaler value: held at zero outside RUN or on clear/load.
  always_comb begin
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (sync_clr || !run || tick) begin
      pre_cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/upcount_ctrl.sv
// Control stage around the external incrementer: run/hold FSM, prescaled
// count capture, programmable modulus and registered wrap pulse.
module upcount_ctrl #(
  parameter int unsigned WIDTH = upcount_pkg::DefaultWidth,
  parameter int unsigned PRE_W = upcount_pkg::DefaultPreW
) (
  input  logic          clk,
  input  logic          rst_n,
  upcount_ctrl_if.slave bus
);
  import upcount_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             tick;

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_tick_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state_q == ST_RUN),
    .sync_clr (bus.clear || bus.load),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  // FSM next state: clear beats everything; stop beats start only in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (bus.stop)  state_d = ST_HOLD;
      ST_HOLD: if (bus.start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (bus.clear) begin
      state_d = ST_IDLE;
    end
  end

  // Count/wrap next state. Wrap is taken from the modulus compare, never from
  // incrementer overflow, so a count above modulus also wraps.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (tick) begin
      if (count_q >= bus.modulus) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = bus.inc_d;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.inc_q   = count_q;
  assign bus.cnt_out = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_upcount_ctrl.sv
// Scoreboard bench for upcount_ctrl: a reference model predicts each cycle's
// outputs when inputs are driven; predictions are popped after the edge.
module tb_upcount_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 24;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         wrap;
    logic [1:0]   st;
  } exp_t;

  logic clk;
  logic rst_n;

  upcount_ctrl_if #(.WIDTH(W), .PRE_W(PW)) bus ();

  upcount_ctrl #(
    .WIDTH (W),
    .PRE_W (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External incrementer.
  assign bus.inc_d = bus.inc_q + 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb[$];

  // Reference model state.
  logic [W-1:0]  m_cnt;
  logic          m_wrap;
  logic [1:0]    m_st;
  logic [PW-1:0] m_pre;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq("cnt_out", 32'(bus.cnt_out), 32'(e.cnt));
    check_eq("inc_q",   32'(bus.inc_q),   32'(e.cnt));
    check_eq("wrap",    32'(bus.wrap),    32'(e.wrap));
    check_eq("state_o", 32'(bus.state_o), 32'(e.st));
    check_eq("busy",    32'(bus.busy),    32'(e.st == 2'b01));
  endtask

  // Predict one clock edge from current inputs, then clock and compare.
  task automatic step();
    exp_t          e;
    logic          tick;
    logic [PW-1:0] pre_n;
    logic [1:0]    st_n;
    logic [W-1:0]  cnt_n;
    logic          wrap_n;
    tick = (m_st == 2'b01) && (m_pre == bus.prescale);
    if (bus.clear || bus.load || m_st != 2'b01 || tick) pre_n = '0;
    else pre_n = m_pre + 1'b1;
    if (bus.clear) st_n = 2'b00;
    else if (m_st == 2'b01) st_n = bus.stop ? 2'b10 : 2'b01;
    else st_n = bus.start ? 2'b01 : m_st;
    wrap_n = 1'b0;
    if (bus.clear) cnt_n = '0;
    else if (bus.load) cnt_n = bus.load_val;
    else if (tick && m_cnt >= bus.modulus) begin
      cnt_n  = '0;
      wrap_n = 1'b1;
    end else if (tick) cnt_n = m_cnt + 4'd1;
    else cnt_n = m_cnt;
    e.cnt = cnt_n; e.wrap = wrap_n; e.st = st_n;
    sb.push_back(e);
    m_cnt = cnt_n; m_wrap = wrap_n; m_st = st_n; m_pre = pre_n;
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    exp_t e;
    #2 rst_n = 1'b0;
    #1;
    m_cnt = '0; m_wrap = 1'b0; m_st = 2'b00; m_pre = '0;
    e.cnt = '0; e.wrap = 1'b0; e.st = 2'b00;
    sb.push_back(e);
    compare_front();
    #3 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.modulus = 4'd15; bus.prescale = '0;
    m_cnt = '0; m_wrap = 1'b0; m_st = 2'b00; m_pre = '0;
    async_reset();

    // Full 0..15,0 sweep at prescale 0.
    pulse_start();
    steps(16);
    check_eq("sweep_wrap_cnt", 32'(bus.cnt_out), 32'd0);
    check_eq("sweep_wrap",     32'(bus.wrap),    32'd1);
    step();
    check_eq("sweep_wrap_once", 32'(bus.wrap), 32'd0);

    // Prescale 3, modulus 5, then hold and resume.
    do_clear();
    bus.prescale = 24'd3; bus.modulus = 4'd5;
    pulse_start();
    steps(3);
    check_eq("pre_no_change", 32'(bus.cnt_out), 32'd0);
    step();
    check_eq("pre_first_tick", 32'(bus.cnt_out), 32'd1);
    steps(20);
    check_eq("pre_wrap_cnt", 32'(bus.cnt_out), 32'd0);
    check_eq("pre_wrap",     32'(bus.wrap),    32'd1);
    steps(5);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    steps(6);
    check_eq("hold_state", 32'(bus.state_o), 32'd2);
    check_eq("hold_cnt",   32'(bus.cnt_out), 32'd1);
    pulse_start();
    steps(4);

    // Load above modulus while running.
    do_clear();
    bus.prescale = '0; bus.modulus = 4'd5;
    pulse_start();
    steps(2);
    check_eq("load_pre_cnt", 32'(bus.cnt_out), 32'd2);
    bus.load = 1'b1; bus.load_val = 4'd9; step(); bus.load = 1'b0;
    check_eq("load_cnt",   32'(bus.cnt_out), 32'd9);
    check_eq("load_state", 32'(bus.state_o), 32'd1);
    step();
    check_eq("load_wrap_cnt", 32'(bus.cnt_out), 32'd0);
    check_eq("load_wrap",     32'(bus.wrap),    32'd1);

    // start+stop conflicts and clear with start.
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    check_eq("both_in_run", 32'(bus.state_o), 32'd2);
    step();
    check_eq("both_in_hold", 32'(bus.state_o), 32'd1);
    bus.stop = 1'b0; bus.clear = 1'b1;
    step();
    bus.start = 1'b0; bus.clear = 1'b0;
    check_eq("clr_start_state", 32'(bus.state_o), 32'd0);
    check_eq("clr_start_cnt",   32'(bus.cnt_out), 32'd0);

    // Modulus 0: count pinned at 0, wrap every tick.
    bus.modulus = '0;
    pulse_start();
    steps(4);
    check_eq("mod0_cnt",  32'(bus.cnt_out), 32'd0);
    check_eq("mod0_wrap", 32'(bus.wrap),    32'd1);

    // Prescale lowered below pre_cnt mid-run: no tick until the counter wraps.
    do_clear();
    bus.modulus = 4'd15; bus.prescale = 24'd6;
    pulse_start();
    steps(4);
    bus.prescale = 24'd1;
    steps(4);
    check_eq("pre_shrink_cnt", 32'(bus.cnt_out), 32'd0);

    // Randomised mix checked by the model.
    for (int i = 0; i < 80; i++) begin
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.stop     = ($urandom_range(0, 7) == 0);
      bus.clear    = ($urandom_range(0, 15) == 0);
      bus.load     = ($urandom_range(0, 11) == 0);
      bus.load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) bus.modulus = 4'($urandom_range(0, 15));
      if (bus.clear || bus.load) bus.prescale = 24'($urandom_range(0, 2));
      step();
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;

    // Asynchronous reset mid-count.
    do_clear();
    bus.modulus = 4'd15; bus.prescale = '0;
    pulse_start();
    steps(7);
    check_eq("pre_reset_cnt", 32'(bus.cnt_out), 32'd7);
    async_reset();
    check_eq("post_reset_cnt", 32'(bus.cnt_out), 32'd0);
    steps(3);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
